// File: rtl/rails_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package rails_pkg;

    localparam logic RAM_OP_READ  = 1'b0;
    localparam logic RAM_OP_WRITE = 1'b1;

    localparam int unsigned RAM_ADDR_W  = 8;
    localparam int unsigned RAM_DATA_W  = 8;
    localparam int unsigned BURST_CNT_W = 4;

    typedef enum logic [1:0] {
        S_CPU,
        S_EXT,
        S_YIELD
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU core and one external master.
// The external master wins contention but is limited to MAX_EXT_BURST stalling grants
// before the CPU is given one forced cycle. Idle CPU cycles can be stolen without a stall.
module ram_arbiter
    import rails_pkg::*;
#(
    parameter int unsigned MAX_EXT_BURST = 4,
    parameter bit          STEAL_IDLE    = 1'b1
) (
    input  logic       clk,
    input  logic       sync_rst,
    input  logic       clk_en,
    output logic       cpu_clk_en,
    input  logic [7:0] cpu_ram_address,
    input  logic [7:0] cpu_ram_write_data,
    input  logic       cpu_ram_operation,
    input  logic       cpu_ram_en,
    output logic [7:0] cpu_ram_read_data,
    input  logic       ext_req_valid,
    output logic       ext_req_ready,
    input  logic [7:0] ext_req_address,
    input  logic [7:0] ext_req_write_data,
    input  logic       ext_req_operation,
    output logic       ext_rsp_valid,
    output logic [7:0] ext_rsp_read_data,
    output logic [7:0] ram_address,
    output logic [7:0] ram_write_data,
    output logic       ram_operation,
    output logic       ram_en,
    input  logic [7:0] ram_read_data
);

    localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_EXT_BURST);

    arb_state_t             r_state;
    logic [BURST_CNT_W-1:0] r_burst_cnt;
    logic                   r_rsp_pending;

    logic                   w_ext_grant;
    logic                   w_steal;
    logic                   w_stall_grant;
    logic [BURST_CNT_W-1:0] w_burst_inc;

    // Grant classification from the current request and arbitration state.
    assign w_ext_grant   = ext_req_valid && (r_state != S_YIELD);
    assign w_steal       = w_ext_grant && STEAL_IDLE && !cpu_ram_en;
    assign w_stall_grant = w_ext_grant && !w_steal;
    assign w_burst_inc   = (r_burst_cnt < BURST_MAX) ? r_burst_cnt + BURST_CNT_W'(1) : r_burst_cnt;

    // Read data from the RAM is shared; the rsp-pending stall keeps the two readers apart.
    assign cpu_ram_read_data = ram_read_data;
    assign ext_rsp_read_data = ram_read_data;
    assign ext_rsp_valid     = r_rsp_pending && clk_en && !sync_rst;

    // RAM mux, ext handshake and CPU clock enable for the current cycle.
    always_comb begin
        ext_req_ready  = 1'b0;
        cpu_clk_en     = 1'b0;
        ram_en         = 1'b0;
        ram_address    = cpu_ram_address;
        ram_write_data = cpu_ram_write_data;
        ram_operation  = cpu_ram_operation;
        if (sync_rst) begin
            cpu_clk_en = clk_en;
        end else if (clk_en) begin
            if (w_ext_grant) begin
                ext_req_ready  = 1'b1;
                cpu_clk_en     = w_steal;
                ram_en         = 1'b1;
                ram_address    = ext_req_address;
                ram_write_data = ext_req_write_data;
                ram_operation  = ext_req_operation;
            end else if (!r_rsp_pending) begin
                cpu_clk_en = 1'b1;
                ram_en     = cpu_ram_en;
            end
        end
    end

    // Arbitration state, burst counter and response-pending flag.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (sync_rst) begin
                r_state       <= S_CPU;
                r_burst_cnt   <= '0;
                r_rsp_pending <= 1'b0;
            end else begin
                r_rsp_pending <= w_ext_grant && (ext_req_operation == RAM_OP_READ);
                if (r_state == S_YIELD) begin
                    r_state     <= S_CPU;
                    r_burst_cnt <= '0;
                end else if (w_stall_grant) begin
                    r_burst_cnt <= w_burst_inc;
                    r_state     <= (w_burst_inc == BURST_MAX) ? S_YIELD : S_EXT;
                end else if (!w_ext_grant) begin
                    r_state     <= S_CPU;
                    r_burst_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and an ext-response scoreboard.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       sync_rst;
    logic       clk_en;
    logic       cpu_clk_en;
    logic [7:0] cpu_ram_address;
    logic [7:0] cpu_ram_write_data;
    logic       cpu_ram_operation;
    logic       cpu_ram_en;
    logic [7:0] cpu_ram_read_data;
    logic       ext_req_valid;
    logic       ext_req_ready;
    logic [7:0] ext_req_address;
    logic [7:0] ext_req_write_data;
    logic       ext_req_operation;
    logic       ext_rsp_valid;
    logic [7:0] ext_rsp_read_data;
    logic [7:0] ram_address;
    logic [7:0] ram_write_data;
    logic       ram_operation;
    logic       ram_en;
    logic [7:0] ram_read_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem    [256];
    logic [7:0] shadow [256];
    logic [7:0] sb_q   [$];

    ram_arbiter #(.MAX_EXT_BURST(4), .STEAL_IDLE(1'b1)) dut (
        .clk                (clk),
        .sync_rst           (sync_rst),
        .clk_en             (clk_en),
        .cpu_clk_en         (cpu_clk_en),
        .cpu_ram_address    (cpu_ram_address),
        .cpu_ram_write_data (cpu_ram_write_data),
        .cpu_ram_operation  (cpu_ram_operation),
        .cpu_ram_en         (cpu_ram_en),
        .cpu_ram_read_data  (cpu_ram_read_data),
        .ext_req_valid      (ext_req_valid),
        .ext_req_ready      (ext_req_ready),
        .ext_req_address    (ext_req_address),
        .ext_req_write_data (ext_req_write_data),
        .ext_req_operation  (ext_req_operation),
        .ext_rsp_valid      (ext_rsp_valid),
        .ext_rsp_read_data  (ext_rsp_read_data),
        .ram_address        (ram_address),
        .ram_write_data     (ram_write_data),
        .ram_operation      (ram_operation),
        .ram_en             (ram_en),
        .ram_read_data      (ram_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data valid the cycle after an enabled read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_operation) mem[ram_address] <= ram_write_data;
            else               ram_read_data    <= mem[ram_address];
        end
    end

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: push expected data on ext read grant, pop on response.
    always @(negedge clk) begin
        if (clk_en && sync_rst) begin
            sb_q.delete();
        end else begin
            if (ext_rsp_valid) begin
                if (sb_q.size() == 0) check("rsp_unexpected", 8'h01, 8'h00);
                else                  check("rsp_data", ext_rsp_read_data, sb_q.pop_front());
            end
            if (clk_en && ext_req_valid && ext_req_ready && (ext_req_operation == 1'b0))
                sb_q.push_back(shadow[ext_req_address]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a burst of ext writes against a busy CPU and checks the grant/yield rhythm.
    task automatic burst_run(input string tag, input logic [7:0] base, input int cycles);
        int  k = 0;
        bit  yld;
        cpu_ram_en        = 1'b1;
        ext_req_valid     = 1'b1;
        ext_req_operation = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            ext_req_address    = base + 8'(k);
            ext_req_write_data = 8'(k);
            @(negedge clk);
            yld = (i % 5 == 4);
            check({tag, "_ready"},  8'(ext_req_ready), yld ? 8'h00 : 8'h01);
            check({tag, "_cpuen"},  8'(cpu_clk_en),    yld ? 8'h01 : 8'h00);
            check({tag, "_addr"},   ram_address,       yld ? cpu_ram_address : base + 8'(k));
            if (!yld) k++;
            tick();
        end
        ext_req_valid = 1'b0;
        cpu_ram_en    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i) ^ 8'h7C;
            shadow[i] = 8'(i) ^ 8'h7C;
        end
        sync_rst = 1'b1; clk_en = 1'b1;
        cpu_ram_address = 8'h00; cpu_ram_write_data = 8'h00; cpu_ram_operation = 1'b0; cpu_ram_en = 1'b1;
        ext_req_valid = 1'b1; ext_req_address = 8'h00; ext_req_write_data = 8'h00; ext_req_operation = 1'b0;

        // Reset behaviour
        @(negedge clk);
        check("rst_ready",  8'(ext_req_ready), 8'h00);
        check("rst_rspv",   8'(ext_rsp_valid), 8'h00);
        check("rst_ramen",  8'(ram_en),        8'h00);
        check("rst_cpuen",  8'(cpu_clk_en),    8'h01);
        tick();
        clk_en = 1'b0;
        @(negedge clk);
        check("rst_cpuen_gated", 8'(cpu_clk_en), 8'h00);
        tick();
        clk_en = 1'b1; ext_req_valid = 1'b0;
        tick();
        sync_rst = 1'b0;

        // CPU pass-through, no ext traffic
        cpu_ram_en = 1'b1; cpu_ram_operation = 1'b0; cpu_ram_address = 8'h10;
        @(negedge clk);
        check("t1_rd_addr", ram_address, 8'h10);
        check("t1_rd_op",   8'(ram_operation), 8'h00);
        check("t1_rd_en",   8'(ram_en),        8'h01);
        check("t1_rd_cpu",  8'(cpu_clk_en),    8'h01);
        tick();
        cpu_ram_operation = 1'b1; cpu_ram_address = 8'h11; cpu_ram_write_data = 8'hAA;
        shadow[8'h11] = 8'hAA;
        @(negedge clk);
        check("t1_rdata",   cpu_ram_read_data, 8'h6C);
        check("t1_wr_addr", ram_address,       8'h11);
        check("t1_wr_data", ram_write_data,    8'hAA);
        check("t1_wr_op",   8'(ram_operation), 8'h01);
        check("t1_wr_cpu",  8'(cpu_clk_en),    8'h01);
        tick();

        // Steal an idle CPU cycle for an ext read
        cpu_ram_en = 1'b0; cpu_ram_operation = 1'b0;
        ext_req_valid = 1'b1; ext_req_operation = 1'b0; ext_req_address = 8'h20;
        @(negedge clk);
        check("t2_ready", 8'(ext_req_ready), 8'h01);
        check("t2_cpuen", 8'(cpu_clk_en),    8'h01);
        check("t2_addr",  ram_address,       8'h20);
        tick();
        ext_req_valid = 1'b0;
        @(negedge clk);
        check("t2_rspv",    8'(ext_rsp_valid),  8'h01);
        check("t2_rdata",   ext_rsp_read_data,  8'h5C);
        check("t2_pend_cpu", 8'(cpu_clk_en),    8'h00);
        tick();
        tick();

        // Bounded burst against a busy CPU
        cpu_ram_address = 8'h30;
        burst_run("t3", 8'h80, 10);

        // CPU read held off by the pending ext response
        ext_req_valid = 1'b1; ext_req_operation = 1'b0; ext_req_address = 8'h21;
        @(negedge clk);
        check("t4_ready", 8'(ext_req_ready), 8'h01);
        tick();
        ext_req_valid = 1'b0; cpu_ram_en = 1'b1; cpu_ram_operation = 1'b0; cpu_ram_address = 8'h40;
        @(negedge clk);
        check("t4_cpuen_stall", 8'(cpu_clk_en),   8'h00);
        check("t4_ramen_stall", 8'(ram_en),       8'h00);
        check("t4_rspv",        8'(ext_rsp_valid), 8'h01);
        check("t4_rdata",       ext_rsp_read_data, 8'h5D);
        tick();
        @(negedge clk);
        check("t4_cpuen", 8'(cpu_clk_en), 8'h01);
        check("t4_ramen", 8'(ram_en),     8'h01);
        check("t4_addr",  ram_address,    8'h40);
        tick();
        cpu_ram_en = 1'b0;
        @(negedge clk);
        check("t4_cpu_rdata", cpu_ram_read_data, 8'h3C);
        tick();

        // Freeze mid-burst with a response pending
        cpu_ram_en = 1'b1; cpu_ram_address = 8'h31;
        ext_req_valid = 1'b1; ext_req_operation = 1'b1; ext_req_address = 8'h90;
        @(negedge clk);
        check("t5_g1_ready", 8'(ext_req_ready), 8'h01);
        check("t5_g1_cpuen", 8'(cpu_clk_en),    8'h00);
        tick();
        ext_req_operation = 1'b0; ext_req_address = 8'h22;
        @(negedge clk);
        check("t5_g2_ready", 8'(ext_req_ready), 8'h01);
        tick();
        ext_req_operation = 1'b1; ext_req_address = 8'h91;
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_frz_ready", 8'(ext_req_ready), 8'h00);
            check("t5_frz_ramen", 8'(ram_en),        8'h00);
            check("t5_frz_cpuen", 8'(cpu_clk_en),    8'h00);
            check("t5_frz_rspv",  8'(ext_rsp_valid), 8'h00);
            tick();
        end
        clk_en = 1'b1;
        @(negedge clk);
        check("t5_g3_ready", 8'(ext_req_ready),  8'h01);
        check("t5_g3_rspv",  8'(ext_rsp_valid),  8'h01);
        check("t5_g3_rdata", ext_rsp_read_data,  8'h5E);
        tick();
        ext_req_address = 8'h92;
        @(negedge clk);
        check("t5_g4_ready", 8'(ext_req_ready), 8'h01);
        tick();
        @(negedge clk);
        check("t5_yld_ready", 8'(ext_req_ready), 8'h00);
        check("t5_yld_cpuen", 8'(cpu_clk_en),    8'h01);
        check("t5_yld_addr",  ram_address,       8'h31);
        tick();
        ext_req_valid = 1'b0; cpu_ram_en = 1'b0;

        // Reset in S_EXT with a response pending
        cpu_ram_en = 1'b1;
        ext_req_valid = 1'b1; ext_req_operation = 1'b0; ext_req_address = 8'h23;
        @(negedge clk);
        check("t6_ready", 8'(ext_req_ready), 8'h01);
        check("t6_cpuen", 8'(cpu_clk_en),    8'h00);
        tick();
        sync_rst = 1'b1; ext_req_valid = 1'b0;
        @(negedge clk);
        check("t6_rst_rspv",  8'(ext_rsp_valid), 8'h00);
        check("t6_rst_ramen", 8'(ram_en),        8'h00);
        check("t6_rst_cpuen", 8'(cpu_clk_en),    8'h01);
        tick();
        sync_rst = 1'b0; cpu_ram_en = 1'b0;
        @(negedge clk);
        check("t6_post_rspv",  8'(ext_rsp_valid), 8'h00);
        check("t6_post_cpuen", 8'(cpu_clk_en),    8'h01);
        tick();
        cpu_ram_address = 8'h32;
        burst_run("t6b", 8'hA0, 5);
        tick();
        tick();

        check("sb_empty", 8'(sb_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
